bram_dma_v2: RTL and testbench
==============================

# bram_dma_v2

Single-channel copy engine between the pooling output buffers and the next layer's input storage. On a `start` command it streams a fixed-length block from one of two pooling result buffers:
- `start=1`: `sa_data` buffer into the systolic-array BRAM.
- `start=2`: `fc_data` buffer into the FC `ifmap` buffer.

It then pulses `dma_done_o`. It sits between the pooling stage and the SA/FC compute stages of the CNN accelerator.

## Interface
- `SA_LEN0`, 1176: words copied for `start=1`, `nth_conv_i=0` (6x14x14).
- `SA_LEN1`, 400: words copied for `start=1`, `nth_conv_i=1` (16x5x5).
- `SA_DST_BASE0`, 0: SA BRAM base address for conv 0.
- `SA_DST_BASE1`, 4096: SA BRAM base address for conv 1.
- `FC_LEN0`, 400: words copied for `start=2`, `nth_conv_i=0`.
- `FC_LEN1`, 120: words copied for `start=2`, `nth_conv_i=1`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 2: command, sampled only in IDLE. 1 = SA copy, 2 = FC copy; 0 and 3 are ignored.
- `nth_conv_i` in 2: layer select, latched with `start`. Bit 0 selects the LEN/BASE set; bit 1 is ignored.
- `sa_data_rden_o` out 1: read enable to the SA-side pooling buffer.
- `sa_data_rdptr_o` out 14: read address.
- `sa_data_rdata_i` in 8: read data, valid the cycle after `rden`.
- `fc_data_rden_o` out 1, `fc_data_rdptr_o` out 10, `fc_data_rdata_i` in 8: FC-side equivalents.
- `sa_wea_o` out 1: SA BRAM write enable.
- `sa_addra_o` out 17: SA BRAM write address.
- `sa_dia_o` out 8: SA BRAM write data.
- `ifmap_wren_o` out 1, `ifmap_wrptr_o` out 10, `ifmap_wdata_o` out 8: ifmap buffer write port.
- `dma_done_o` out 1: one-cycle completion pulse.

## Operation
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE, `start` ∈ {1,2}:
  - Latch the channel, LEN (from `nth_conv_i[0]`) and destination base (SA only; the FC base is 0).
  - Clear the index counter and go to READ.
- READ:
  - Assert the selected `rden`, with `rdptr` = index, where index runs 0..LEN-1 and increments every cycle.
  - Go to DRAIN after issuing index LEN-1.
- Write side: a registered copy of the read request, delayed 1 cycle.
  - `wea`/`wren` = delayed `rden`.
  - Address = base + delayed index; FC address = delayed index.
  - Write data = the channel's `rdata_i`, combinational pass-through, gated to 0 when write enable is low.
- DRAIN: completes the final write, then goes to DONE.
- DONE: `dma_done_o`=1 for one cycle, then IDLE.
- The inactive channel's outputs stay 0 throughout.
- A `start` arriving outside IDLE is ignored; there is no queuing.
- `rdptr` is at most LEN-1, so there is no wrap. A destination address overflowing 17 bits wraps modulo 2^17; this is a parameter misuse and is not detected.
- Reset mid-transfer aborts immediately and returns to IDLE. No done pulse is issued; partial writes stand.

## Timing
- Reset values: all outputs 0, state IDLE.
- `start` is sampled at edge E0. Read index k is presented in cycle E0+1+k. Write k occurs in cycle E0+2+k.
- `dma_done_o` is high in cycle E0+LEN+2.
- IDLE is re-entered at E0+LEN+3, and a new `start` is accepted at that edge.
- Total latency, start to done: LEN+2 cycles.
- `start` is a level sampled per cycle in IDLE. A start held high re-triggers after done.

## Configuration
- `BRAM_DMA_ASSERT_EN`: when defined, simulation-only assertions are compiled in:
  - `start` ∉ {0} while not IDLE is flagged (warning).
  - `start`=3 is flagged (error).
  - Write enable never coincides with an all-zero LEN.
- Undefined: no assertion code; RTL behaviour is identical either way.

## Structure
- `bram_dma_pkg` holds:
  - the FSM state enum;
  - the channel enum (CH_SA=1, CH_FC=2);
  - default LEN/BASE constants;
  - address widths (14, 10, 17, 10).
- One natural sub-module, `bram_dma_addr_gen`: index counter plus 1-cycle delayed write-index/valid pipeline, shared by both channels.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles → every output reads 0.
- `start=1`, `nth_conv_i=0`, `sa_data_rdata_i` = low byte of the previous `rdptr`:
  - 1176 reads, `rdptr` 0..1175.
  - `sa_wea_o` 1176 cycles, `sa_addra_o` 0..1175.
  - `dma_done_o` exactly at E0+1178.
  - `fc_*` and `ifmap_*` stay 0.
- `start=1`, `nth_conv_i=1`: 400 writes at `sa_addra_o` 4096..4495, done at E0+402.
- `start=2`, `nth_conv_i=0`: 400 `ifmap` writes at `wrptr` 0..399, data mirrors `fc_data_rdata_i`, done at E0+402. `nth_conv_i=1` → 120 writes, done at E0+122.
- Pulse `start=2` mid SA transfer, and `start=3` in IDLE → both ignored; the SA transfer completes unchanged.
- Deassert `rst_n` at write 50 of a transfer → outputs 0 immediately, no done pulse; the next `start=1` runs a full transfer.

Source files
------------

// File: rtl/bram_dma_pkg.sv
// bram_dma_pkg: shared types, widths and default block sizes for the bram_dma_v2 copy engine
package bram_dma_pkg;

    localparam int SA_RD_W = 14;
    localparam int FC_RD_W = 10;
    localparam int SA_WR_W = 17;
    localparam int FC_WR_W = 10;
    localparam int IDX_W   = 14;

    localparam int unsigned DEF_SA_LEN0      = 1176;
    localparam int unsigned DEF_SA_LEN1      = 400;
    localparam int unsigned DEF_SA_DST_BASE0 = 0;
    localparam int unsigned DEF_SA_DST_BASE1 = 4096;
    localparam int unsigned DEF_FC_LEN0      = 400;
    localparam int unsigned DEF_FC_LEN1      = 120;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        CH_NONE = 2'd0,
        CH_SA   = 2'd1,
        CH_FC   = 2'd2
    } chan_e;

    function automatic logic is_cmd(input logic [1:0] s);
        return (s == 2'd1) || (s == 2'd2);
    endfunction

endpackage

// File: rtl/bram_dma_addr_gen.sv
// bram_dma_addr_gen: read index counter with a one-cycle delayed write index/valid copy
module bram_dma_addr_gen
    import bram_dma_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             wr_vld_o,
    output logic [IDX_W-1:0] wr_idx_o
);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] wr_idx_q;
    logic             wr_vld_q;

    // clear on a new command, advance once per issued read
    always_comb begin
        idx_d = clr_i ? '0 : en_i ? idx_q + IDX_W'(1) : idx_q;
    end

    // counter and write-side copy of the read request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= '0;
            wr_vld_q <= 1'b0;
            wr_idx_q <= '0;
        end else begin
            idx_q    <= idx_d;
            wr_vld_q <= en_i;
            wr_idx_q <= idx_q;
        end
    end

    assign idx_o    = idx_q;
    assign wr_vld_o = wr_vld_q;
    assign wr_idx_o = wr_idx_q;

endmodule

// File: rtl/bram_dma_v2.sv
// bram_dma_v2: copies a pooling buffer into SA BRAM or the FC ifmap buffer; BRAM_DMA_ASSERT_EN adds sim checks
module bram_dma_v2
    import bram_dma_pkg::*;
#(
    parameter int unsigned SA_LEN0      = DEF_SA_LEN0,
    parameter int unsigned SA_LEN1      = DEF_SA_LEN1,
    parameter int unsigned SA_DST_BASE0 = DEF_SA_DST_BASE0,
    parameter int unsigned SA_DST_BASE1 = DEF_SA_DST_BASE1,
    parameter int unsigned FC_LEN0      = DEF_FC_LEN0,
    parameter int unsigned FC_LEN1      = DEF_FC_LEN1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         start,
    input  logic [1:0]         nth_conv_i,
    output logic               sa_data_rden_o,
    output logic [SA_RD_W-1:0] sa_data_rdptr_o,
    input  logic [7:0]         sa_data_rdata_i,
    output logic               fc_data_rden_o,
    output logic [FC_RD_W-1:0] fc_data_rdptr_o,
    input  logic [7:0]         fc_data_rdata_i,
    output logic               sa_wea_o,
    output logic [SA_WR_W-1:0] sa_addra_o,
    output logic [7:0]         sa_dia_o,
    output logic               ifmap_wren_o,
    output logic [FC_WR_W-1:0] ifmap_wrptr_o,
    output logic [7:0]         ifmap_wdata_o,
    output logic               dma_done_o
);

    state_e             state_q, state_d;
    chan_e              chan_q, chan_d;
    logic [IDX_W-1:0]   len_q, len_d;
    logic [SA_WR_W-1:0] base_q, base_d;
    logic               clr, rd_en, wr_vld, sa_sel, fc_sel;
    logic [IDX_W-1:0]   idx, wr_idx;
    logic               unused_nth;

    assign unused_nth = nth_conv_i[1];

    bram_dma_addr_gen u_addr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (clr),
        .en_i     (rd_en),
        .idx_o    (idx),
        .wr_vld_o (wr_vld),
        .wr_idx_o (wr_idx)
    );

    // command latch in IDLE, read issue until the last index, then drain and done
    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        len_d   = len_q;
        base_d  = base_q;
        clr     = 1'b0;
        rd_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (is_cmd(start)) begin
                    state_d = ST_READ;
                    chan_d  = chan_e'(start);
                    clr     = 1'b1;
                    len_d   = (start == 2'd1)
                            ? (nth_conv_i[0] ? IDX_W'(SA_LEN1) : IDX_W'(SA_LEN0))
                            : (nth_conv_i[0] ? IDX_W'(FC_LEN1) : IDX_W'(FC_LEN0));
                    base_d  = (start == 2'd1)
                            ? (nth_conv_i[0] ? SA_WR_W'(SA_DST_BASE1) : SA_WR_W'(SA_DST_BASE0))
                            : '0;
                end
            end
            ST_READ: begin
                rd_en = 1'b1;
                if (idx == len_q - IDX_W'(1)) state_d = ST_DRAIN;
            end
            ST_DRAIN: state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // state and latched command registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            chan_q  <= CH_NONE;
            len_q   <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            len_q   <= len_d;
            base_q  <= base_d;
        end
    end

    assign sa_sel = chan_q == CH_SA;
    assign fc_sel = chan_q == CH_FC;

    // every port of the idle channel, and every idle field, is held at 0
    assign sa_data_rden_o  = rd_en & sa_sel;
    assign sa_data_rdptr_o = sa_data_rden_o ? idx : '0;
    assign fc_data_rden_o  = rd_en & fc_sel;
    assign fc_data_rdptr_o = fc_data_rden_o ? idx[FC_RD_W-1:0] : '0;

    assign sa_wea_o      = wr_vld & sa_sel;
    assign sa_addra_o    = sa_wea_o ? base_q + SA_WR_W'(wr_idx) : '0;
    assign sa_dia_o      = sa_wea_o ? sa_data_rdata_i : '0;
    assign ifmap_wren_o  = wr_vld & fc_sel;
    assign ifmap_wrptr_o = ifmap_wren_o ? wr_idx[FC_WR_W-1:0] : '0;
    assign ifmap_wdata_o = ifmap_wren_o ? fc_data_rdata_i : '0;

    assign dma_done_o = state_q == ST_DONE;

`ifdef BRAM_DMA_ASSERT_EN
    a_start_busy: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q != ST_IDLE) |-> (start == 2'd0))
        else $warning("bram_dma_v2: start while busy is ignored");

    a_start_bad: assert property (@(posedge clk) disable iff (!rst_n)
        start != 2'd3)
        else $error("bram_dma_v2: start=3 is not a valid command");

    a_len_zero: assert property (@(posedge clk) disable iff (!rst_n)
        (sa_wea_o || ifmap_wren_o) |-> (len_q != '0))
        else $error("bram_dma_v2: write with zero block length");
`endif

endmodule

// File: tb/tb_bram_dma_v2.sv
// tb_bram_dma_v2: scoreboard bench for bram_dma_v2 against a queue-based transfer model
module tb_bram_dma_v2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  start = 2'd0;
    logic [1:0]  nth = 2'd0;
    logic        sa_rden, fc_rden, sa_wea, ifm_wren, done;
    logic [13:0] sa_rdptr;
    logic [9:0]  fc_rdptr, ifm_wrptr;
    logic [16:0] sa_addra;
    logic [7:0]  sa_rdata = 8'd0, fc_rdata = 8'd0, sa_dia, ifm_wdata;

    bram_dma_v2 dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .nth_conv_i      (nth),
        .sa_data_rden_o  (sa_rden),
        .sa_data_rdptr_o (sa_rdptr),
        .sa_data_rdata_i (sa_rdata),
        .fc_data_rden_o  (fc_rden),
        .fc_data_rdptr_o (fc_rdptr),
        .fc_data_rdata_i (fc_rdata),
        .sa_wea_o        (sa_wea),
        .sa_addra_o      (sa_addra),
        .sa_dia_o        (sa_dia),
        .ifmap_wren_o    (ifm_wren),
        .ifmap_wrptr_o   (ifm_wrptr),
        .ifmap_wdata_o   (ifm_wdata),
        .dma_done_o      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int addr;
        int data;
        int cyc;
    } ev_t;

    ev_t        rdq[$];
    ev_t        wrq[$];
    int         doneq[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         e0;
    logic [7:0] sa_mem[16384];
    logic [7:0] fc_mem[1024];

    always @(posedge clk) cyc <= cyc + 1;

    // source buffers: data one cycle after a read, noise otherwise
    always @(posedge clk) begin
        sa_rdata <= sa_rden ? sa_mem[sa_rdptr] : 8'($urandom);
        fc_rdata <= fc_rden ? fc_mem[fc_rdptr] : 8'($urandom);
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic longint pk(input int ch, input int addr, input int data, input int c);
        return {4'(ch), 20'(addr), 8'(data), 32'(c)};
    endfunction

    function automatic int exp_len(input int s, input int n);
        return (s == 1) ? ((n % 2) ? 400 : 1176) : ((n % 2) ? 120 : 400);
    endfunction

    task automatic push(input int s, input int n, input int t0);
        int len = exp_len(s, n);
        int base = (s == 1 && (n % 2) == 1) ? 4096 : 0;
        for (int k = 0; k < len; k++) begin
            rdq.push_back('{s, k, 0, t0 + k});
            wrq.push_back('{s, (base + k) % 131072,
                            (s == 1) ? int'(sa_mem[k]) : int'(fc_mem[k]), t0 + 1 + k});
        end
        doneq.push_back(t0 + len + 1);
    endtask

    task automatic wait_idle(input int bound, input string nm);
        int i = 0;
        while ((rdq.size() + wrq.size() + doneq.size()) != 0 && i < bound) begin
            @(negedge clk); #1;
            i++;
        end
        chk(nm, rdq.size() + wrq.size() + doneq.size(), 0);
    endtask

    task automatic run(input int s, input int n, input int poke_at, input int poke_v);
        int t0;
        @(negedge clk); #1;
        start = 2'(s);
        nth = 2'(n);
        t0 = cyc + 1;
        push(s, n, t0);
        @(negedge clk); #1;
        start = 2'd0;
        if (poke_at > 0) begin
            repeat (poke_at) @(negedge clk);
            #1 start = 2'(poke_v);
            @(negedge clk); #1;
            start = 2'd0;
        end
        wait_idle(exp_len(s, n) + 20, "drain");
    endtask

    // monitor: compare every read, write and done against the scoreboard
    always @(negedge clk) begin
        ev_t e;
        if (rst_n) begin
            chk("idle_zero",
                (sa_rden && fc_rden) || (sa_wea && ifm_wren) ||
                (!sa_rden && sa_rdptr != 0) || (!fc_rden && fc_rdptr != 0) ||
                (!sa_wea && (sa_addra != 0 || sa_dia != 0)) ||
                (!ifm_wren && (ifm_wrptr != 0 || ifm_wdata != 0)), 0);
            if (sa_rden || fc_rden) begin
                if (rdq.size() == 0) chk("rd_unexpected", cyc, -1);
                else begin
                    e = rdq.pop_front();
                    chk("rd", pk(sa_rden ? 1 : 2, sa_rden ? int'(sa_rdptr) : int'(fc_rdptr), 0, cyc),
                        pk(e.ch, e.addr, 0, e.cyc));
                end
            end
            if (sa_wea || ifm_wren) begin
                if (wrq.size() == 0) chk("wr_unexpected", cyc, -1);
                else begin
                    e = wrq.pop_front();
                    chk("wr", pk(sa_wea ? 1 : 2, sa_wea ? int'(sa_addra) : int'(ifm_wrptr),
                                 sa_wea ? int'(sa_dia) : int'(ifm_wdata), cyc),
                        pk(e.ch, e.addr, e.data, e.cyc));
                end
            end
            if (done) begin
                if (doneq.size() == 0) chk("done_unexpected", cyc, -1);
                else chk("done_cyc", cyc, doneq.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        foreach (sa_mem[i]) sa_mem[i] = 8'($urandom);
        foreach (fc_mem[i]) fc_mem[i] = 8'($urandom);
        repeat (3) @(negedge clk);
        #1;
        chk("reset_rd", {sa_rden, sa_rdptr, fc_rden, fc_rdptr}, 0);
        chk("reset_wr", {sa_wea, sa_addra, sa_dia}, 0);
        chk("reset_if", {ifm_wren, ifm_wrptr, ifm_wdata, done}, 0);
        rst_n = 1'b1;

        run(1, 0, 300, 2);
        run(1, 1, 0, 0);
        run(2, 0, 0, 0);
        run(2, 1, 0, 0);

        @(negedge clk); #1;
        start = 2'd3;
        @(negedge clk); #1;
        start = 2'd0;
        chk("start3_ignored", {sa_rden, fc_rden}, 0);
        repeat (5) @(negedge clk);
        #1;

        repeat (4) run($urandom_range(1, 2), $urandom_range(0, 3), 0, 0);

        @(negedge clk); #1;
        start = 2'd2;
        nth = 2'd1;
        e0 = cyc + 1;
        push(2, 1, e0);
        push(2, 1, e0 + 123);
        while (cyc < e0 + 125) begin
            @(negedge clk); #1;
        end
        start = 2'd0;
        wait_idle(400, "retrigger");

        @(negedge clk); #1;
        start = 2'd1;
        nth = 2'd0;
        e0 = cyc + 1;
        push(1, 0, e0);
        @(negedge clk); #1;
        start = 2'd0;
        while (cyc < e0 + 51) begin
            @(negedge clk); #1;
        end
        rst_n = 1'b0;
        rdq.delete();
        wrq.delete();
        doneq.delete();
        #1;
        chk("abort_rd", {sa_rden, sa_rdptr, fc_rden, fc_rdptr}, 0);
        chk("abort_wr", {sa_wea, sa_addra, sa_dia}, 0);
        chk("abort_if", {ifm_wren, ifm_wrptr, ifm_wdata, done}, 0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        chk("post_abort_idle", {sa_rden, sa_wea, done}, 0);
        run(1, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
